ex_stage_md: RTL and testbench
==============================

EX_STAGE_MD -- requirements
Module: ex_stage_md
Interface
REQ-001 Parameter XLEN, 32, datapath width (even, >=8).
REQ-002 Parameter REGW, 5, register-select width.
REQ-003 One clock; reset is synchronous and active-low; ports are named clock and reset.
REQ-004 clock  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 flush  in  1  kill the in-flight op and the output slot.
REQ-007 in_valid  in  1  decode presents an op.
REQ-008 in_ready  out  1  stage accepts op this cycle.
REQ-009 in_pc  in  XLEN  op PC.
REQ-010 in_rd  in  REGW  destination register.
REQ-011 in_rs1  in  REGW  source 1 select.
REQ-012 in_rs2  in  REGW  source 2 select.
REQ-013 in_data1  in  XLEN  register-file value for rs1.
REQ-014 in_data2  in  XLEN  register-file value for rs2.
REQ-015 in_imm  in  XLEN  sign-extended immediate.
REQ-016 in_ctl  in  4  {is_load, is_store, is_wb, is_imm}.
REQ-017 in_md  in  3  {is_md, md_op[1:0]}; md_op 00 MUL, 01 MULHU, 10 DIVU, 11 REMU.
REQ-018 alu_a  out  XLEN  forwarded operand A to external ALU.
REQ-019 alu_b  out  XLEN  operand B to external ALU (imm if is_imm).
REQ-020 alu_result  in  XLEN  external ALU result, combinational.
REQ-021 alu_branch  in  1  external ALU branch-taken.
REQ-022 wb_is_wb  in  1  writeback stage writes a register.
REQ-023 wb_rd  in  REGW  writeback destination.
REQ-024 wb_result  in  XLEN  writeback value.
REQ-025 out_ready  in  1  downstream accepts the output slot.
REQ-026 out_valid  out  1  output slot holds a valid op.
REQ-027 out_pc  out  XLEN  registered PC.
REQ-028 out_rd  out  REGW  registered destination.
REQ-029 out_ctl  out  3  registered {is_load, is_store, is_wb}.
REQ-030 out_result  out  XLEN  ALU or MD result.
REQ-031 out_store_data  out  XLEN  forwarded rs2 value for stores.
REQ-032 out_br_addr  out  XLEN  in_pc + in_imm, modulo 2^XLEN.
REQ-033 out_br_en  out  1  registered alu_branch (forced 0 for MD ops).
Function
REQ-034 Forwarding per source: rs==0 -> register-file value; else own slot (out_valid, out_ctl.is_wb, !out_ctl.is_load, out_rd==rs) -> out_result; else wb (wb_is_wb, wb_rd==rs) -> wb_result; else register file.
REQ-035 in_ready = !flush && state==IDLE && (!out_valid || out_ready); accept = in_valid && in_ready.
REQ-036 ALU op (is_md=0): accepted at edge N -> out_* loaded and out_valid=1 at edge N; latency 1.
REQ-037 MD op: FSM IDLE -> CALC on accept, capturing forwarded operands; CALC runs exactly XLEN cycles (one bit per cycle, shift-add multiply, restoring divide); CALC -> DONE.
REQ-038 DONE: when !out_valid || out_ready, load out_* (out_valid=1, out_br_en=0) and return to IDLE; otherwise hold DONE; no output bubble beyond this.
REQ-039 MD results: MUL low XLEN bits, MULHU high XLEN bits (unsigned); DIVU/REMU unsigned; divide by zero -> DIVU all ones, REMU dividend.
REQ-040 Output slot holds all out_* stable while out_valid && !out_ready; if out_ready and no new load, out_valid clears.
REQ-041 Simultaneous drain and new load on the same edge replaces the slot with the new op.
REQ-042 flush (reset inactive): next edge out_valid=0, FSM -> IDLE, MD progress discarded, no accept that cycle.
REQ-043 Priority: reset > flush > load > hold.
Reset
REQ-044 reset=0 at an edge: all out_* = 0, out_valid = 0, FSM = IDLE, MD registers cleared, including mid-CALC.
Verification
REQ-045 ADD x3 (result 5), next op rs1=x3, data1=0 -> alu_a = 5; same with rd=x0 -> alu_a = data1.
REQ-046 MUL 0xFFFFFFFF*2 (XLEN=32) -> out_result 0xFFFFFFFE at edge accept+33; MULHU same operands -> 0x00000001; in_ready=0 throughout.
REQ-047 DIVU 7/0 -> 0xFFFFFFFF; REMU 7/0 -> 7; DIVU 100/7 -> 14, REMU -> 2.
REQ-048 out_ready=0 for 3 cycles after ALU result -> out_* stable, in_ready=0; out_ready=1 with in_valid=1 -> slot replaced same edge; flush mid-CALC -> out_valid=0, in_ready=1 next cycle.

Source files
------------

// File: rtl/ex_stage_md.sv
// rtl/ex_stage_md.sv - execute stage with operand forwarding and an iterative multiply/divide unit
// ALU ops complete in one cycle through an external ALU; MD ops iterate one bit per cycle.
module ex_stage_md #(
   parameter int XLEN = 32,
   parameter int REGW = 5
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_pc,
   input  logic [REGW-1:0] in_rd,
   input  logic [REGW-1:0] in_rs1,
   input  logic [REGW-1:0] in_rs2,
   input  logic [XLEN-1:0] in_data1,
   input  logic [XLEN-1:0] in_data2,
   input  logic [XLEN-1:0] in_imm,
   input  logic [3:0]      in_ctl,
   input  logic [2:0]      in_md,
   output logic [XLEN-1:0] alu_a,
   output logic [XLEN-1:0] alu_b,
   input  logic [XLEN-1:0] alu_result,
   input  logic            alu_branch,
   input  logic            wb_is_wb,
   input  logic [REGW-1:0] wb_rd,
   input  logic [XLEN-1:0] wb_result,
   input  logic            out_ready,
   output logic            out_valid,
   output logic [XLEN-1:0] out_pc,
   output logic [REGW-1:0] out_rd,
   output logic [2:0]      out_ctl,
   output logic [XLEN-1:0] out_result,
   output logic [XLEN-1:0] out_store_data,
   output logic [XLEN-1:0] out_br_addr,
   output logic            out_br_en
);

   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q;
   logic [XLEN-1:0] hi_q, lo_q, hi_d, lo_d, div_q;
   logic [1:0]      md_op_q;
   logic [XLEN-1:0] md_pc_q, md_br_q;
   logic [REGW-1:0] md_rd_q;
   logic [2:0]      md_ctl_q;

   logic            out_valid_q, out_br_en_q;
   logic [XLEN-1:0] out_pc_q, out_result_q, out_store_q, out_br_addr_q;
   logic [REGW-1:0] out_rd_q;
   logic [2:0]      out_ctl_q;

   logic            slot_free, accept, load_alu, load_md;
   logic            slot_hit1, slot_hit2, wb_hit1, wb_hit2;
   logic [XLEN-1:0] fwd1, fwd2;
   logic [XLEN:0]   mul_sum, div_rs, div_diff;

   // A slot result is forwardable only if it writes a register and is not a load.
   assign slot_hit1 = (in_rs1 != '0) && out_valid_q && out_ctl_q[0] && !out_ctl_q[2] && (out_rd_q == in_rs1);
   assign slot_hit2 = (in_rs2 != '0) && out_valid_q && out_ctl_q[0] && !out_ctl_q[2] && (out_rd_q == in_rs2);
   assign wb_hit1   = (in_rs1 != '0) && wb_is_wb && (wb_rd == in_rs1);
   assign wb_hit2   = (in_rs2 != '0) && wb_is_wb && (wb_rd == in_rs2);
   assign fwd1      = slot_hit1 ? out_result_q : (wb_hit1 ? wb_result : in_data1);
   assign fwd2      = slot_hit2 ? out_result_q : (wb_hit2 ? wb_result : in_data2);
   assign alu_a     = fwd1;
   assign alu_b     = in_ctl[0] ? in_imm : fwd2;

   assign slot_free = !out_valid_q || out_ready;
   assign in_ready  = !flush && (state_q == IDLE) && slot_free;
   assign accept    = in_valid && in_ready;
   assign load_alu  = accept && !in_md[2];
   assign load_md   = !flush && (state_q == DONE) && slot_free;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept && in_md[2]) state_d = CALC;
         CALC:    if (cnt_q == CW'(XLEN - 1)) state_d = DONE;
         DONE:    if (slot_free) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (flush) state_d = IDLE;
   end

   // hi/lo form the product register for multiply and remainder/quotient for divide.
   assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, div_q} : '0);
   assign div_rs   = {hi_q, lo_q[XLEN-1]};
   assign div_diff = div_rs - {1'b0, div_q};

   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      if (!md_op_q[1]) begin
         hi_d = mul_sum[XLEN:1];
         lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
      end else if (!div_diff[XLEN]) begin
         hi_d = div_diff[XLEN-1:0];
         lo_d = {lo_q[XLEN-2:0], 1'b1};
      end else begin
         hi_d = div_rs[XLEN-1:0];
         lo_d = {lo_q[XLEN-2:0], 1'b0};
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         div_q    <= '0;
         md_op_q  <= '0;
         md_pc_q  <= '0;
         md_br_q  <= '0;
         md_rd_q  <= '0;
         md_ctl_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept && in_md[2]) begin
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= fwd1;
            div_q    <= fwd2;
            md_op_q  <= in_md[1:0];
            md_pc_q  <= in_pc;
            md_br_q  <= in_pc + in_imm;
            md_rd_q  <= in_rd;
            md_ctl_q <= in_ctl[3:1];
         end else if (state_q == CALC && !flush) begin
            cnt_q <= cnt_q + CW'(1);
            hi_q  <= hi_d;
            lo_q  <= lo_d;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         out_valid_q   <= 1'b0;
         out_pc_q      <= '0;
         out_rd_q      <= '0;
         out_ctl_q     <= '0;
         out_result_q  <= '0;
         out_store_q   <= '0;
         out_br_addr_q <= '0;
         out_br_en_q   <= 1'b0;
      end else if (flush) begin
         out_valid_q <= 1'b0;
      end else if (load_alu) begin
         out_valid_q   <= 1'b1;
         out_pc_q      <= in_pc;
         out_rd_q      <= in_rd;
         out_ctl_q     <= in_ctl[3:1];
         out_result_q  <= alu_result;
         out_store_q   <= fwd2;
         out_br_addr_q <= in_pc + in_imm;
         out_br_en_q   <= alu_branch;
      end else if (load_md) begin
         out_valid_q   <= 1'b1;
         out_pc_q      <= md_pc_q;
         out_rd_q      <= md_rd_q;
         out_ctl_q     <= md_ctl_q;
         out_result_q  <= md_op_q[0] ? hi_q : lo_q;
         out_store_q   <= div_q;
         out_br_addr_q <= md_br_q;
         out_br_en_q   <= 1'b0;
      end else if (out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign out_valid      = out_valid_q;
   assign out_pc         = out_pc_q;
   assign out_rd         = out_rd_q;
   assign out_ctl        = out_ctl_q;
   assign out_result     = out_result_q;
   assign out_store_data = out_store_q;
   assign out_br_addr    = out_br_addr_q;
   assign out_br_en      = out_br_en_q;

endmodule

// File: tb/tb_ex_stage_md.sv
// tb/tb_ex_stage_md.sv - directed bench for ex_stage_md
module tb_ex_stage_md;

   logic        clock, reset, flush, in_valid, in_ready;
   logic [31:0] in_pc, in_data1, in_data2, in_imm, alu_a, alu_b, alu_result, wb_result;
   logic [4:0]  in_rd, in_rs1, in_rs2, wb_rd, out_rd;
   logic [3:0]  in_ctl;
   logic [2:0]  in_md, out_ctl;
   logic        alu_branch, wb_is_wb, out_ready, out_valid, out_br_en;
   logic [31:0] out_pc, out_result, out_store_data, out_br_addr;

   int n_cmp = 0;
   int n_err = 0;

   ex_stage_md #(.XLEN(32), .REGW(5)) dut (
      .clock(clock), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_rd(in_rd),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_data1(in_data1), .in_data2(in_data2),
      .in_imm(in_imm), .in_ctl(in_ctl), .in_md(in_md),
      .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result), .alu_branch(alu_branch),
      .wb_is_wb(wb_is_wb), .wb_rd(wb_rd), .wb_result(wb_result),
      .out_ready(out_ready), .out_valid(out_valid), .out_pc(out_pc), .out_rd(out_rd),
      .out_ctl(out_ctl), .out_result(out_result), .out_store_data(out_store_data),
      .out_br_addr(out_br_addr), .out_br_en(out_br_en)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_op(input logic [4:0] rd, rs1, rs2, input logic [31:0] d1, d2, imm, pc,
                         input logic [3:0] ctl, input logic [2:0] md, input logic [31:0] res,
                         input logic br);
      in_valid = 1'b1; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
      in_data1 = d1; in_data2 = d2; in_imm = imm; in_pc = pc;
      in_ctl = ctl; in_md = md; alu_result = res; alu_branch = br;
   endtask

   task automatic run_md(input string tag, input logic [2:0] md, input logic [31:0] a, b, exp);
      int bad;
      bad = 0;
      set_op(5'd9, 5'd7, 5'd8, a, b, 32'h4, 32'h200, 4'b0010, md, 32'hDEAD, 1'b1);
      #1 chk({tag, "_rdy"}, in_ready, 1);
      tick;
      in_valid = 1'b0;
      for (int i = 1; i <= 32; i++) begin
         tick;
         if (in_ready !== 1'b0 || out_valid !== 1'b0) bad++;
      end
      chk({tag, "_busy"}, bad, 0);
      tick;
      chk({tag, "_valid"}, out_valid, 1);
      chk({tag, "_result"}, out_result, exp);
      chk({tag, "_bren"}, out_br_en, 0);
      chk({tag, "_braddr"}, out_br_addr, 32'h204);
      chk({tag, "_rd"}, out_rd, 9);
      chk({tag, "_store"}, out_store_data, b);
   endtask

   initial begin
      int bad;
      reset = 1'b0; flush = 1'b0; out_ready = 1'b1;
      wb_is_wb = 1'b0; wb_rd = '0; wb_result = '0;
      set_op('0, '0, '0, '0, '0, '0, '0, 4'b0, 3'b0, '0, 1'b0);
      in_valid = 1'b0;
      tick; tick;
      chk("rst_valid", out_valid, 0);
      chk("rst_result", out_result, 0);
      reset = 1'b1;
      #1 chk("rst_ready", in_ready, 1);

      // ADD x3 = 2 + 3 with immediate path check
      set_op(5'd3, 5'd1, 5'd2, 32'd2, 32'd3, 32'h10, 32'h100, 4'b0011, 3'b0, 32'd5, 1'b1);
      #1 chk("add_imm_b", alu_b, 32'h10);
      in_ctl = 4'b0010;
      #1 chk("add_a", alu_a, 2);
      chk("add_b", alu_b, 3);
      tick;
      chk("add_valid", out_valid, 1);
      chk("add_result", out_result, 5);
      chk("add_rd", out_rd, 3);
      chk("add_ctl", out_ctl, 3'b001);
      chk("add_pc", out_pc, 32'h100);
      chk("add_braddr", out_br_addr, 32'h110);
      chk("add_bren", out_br_en, 1);
      chk("add_store", out_store_data, 3);

      // Backpressure with forwarding checks while the slot is held
      out_ready = 1'b0;
      wb_is_wb = 1'b1; wb_rd = 5'd4; wb_result = 32'h77;
      set_op(5'd6, 5'd3, 5'd4, 32'd0, 32'h55, 32'h8, 32'h120, 4'b0010, 3'b0, 32'd9, 1'b0);
      #1 chk("hold_ready", in_ready, 0);
      chk("fwd_slot_a", alu_a, 5);
      chk("fwd_wb_b", alu_b, 32'h77);
      in_rs1 = 5'd0; in_data1 = 32'h11;
      #1 chk("fwd_x0_a", alu_a, 32'h11);
      in_rs2 = 5'd3; wb_rd = 5'd3;
      #1 chk("fwd_prio_b", alu_b, 5);
      in_rs1 = 5'd3; in_data1 = 32'd0; in_rs2 = 5'd4; wb_rd = 5'd4;
      for (int i = 0; i < 3; i++) begin
         tick;
         chk("hold_result", out_result, 5);
         chk("hold_pc", out_pc, 32'h100);
         chk("hold_valid", out_valid, 1);
      end
      out_ready = 1'b1;
      #1 chk("repl_ready", in_ready, 1);
      tick;
      chk("repl_result", out_result, 9);
      chk("repl_rd", out_rd, 6);
      chk("repl_pc", out_pc, 32'h120);
      chk("repl_bren", out_br_en, 0);
      chk("repl_store", out_store_data, 32'h77);
      in_valid = 1'b0; wb_is_wb = 1'b0;
      tick;
      chk("drain_valid", out_valid, 0);

      run_md("mul",   3'b100, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE);
      run_md("mulhu", 3'b101, 32'hFFFFFFFF, 32'd2, 32'h00000001);
      run_md("divu0", 3'b110, 32'd7, 32'd0, 32'hFFFFFFFF);
      run_md("remu0", 3'b111, 32'd7, 32'd0, 32'd7);
      run_md("divu",  3'b110, 32'd100, 32'd7, 32'd14);
      run_md("remu",  3'b111, 32'd100, 32'd7, 32'd2);

      // Flush in the middle of a multiply
      set_op(5'd9, 5'd7, 5'd8, 32'd3, 32'd4, 32'h4, 32'h300, 4'b0010, 3'b100, 32'd0, 1'b0);
      tick;
      in_valid = 1'b0;
      repeat (5) tick;
      flush = 1'b1;
      #1 chk("flush_ready0", in_ready, 0);
      tick;
      flush = 1'b0;
      chk("flush_valid", out_valid, 0);
      #1 chk("flush_ready1", in_ready, 1);
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         tick;
         if (out_valid !== 1'b0) bad++;
      end
      chk("flush_discard", bad, 0);

      // Reset in the middle of a divide
      set_op(5'd9, 5'd7, 5'd8, 32'd50, 32'd5, 32'h4, 32'h400, 4'b0010, 3'b110, 32'd0, 1'b0);
      tick;
      in_valid = 1'b0;
      repeat (3) tick;
      reset = 1'b0;
      tick;
      reset = 1'b1;
      chk("mrst_result", out_result, 0);
      chk("mrst_braddr", out_br_addr, 0);
      chk("mrst_pc", out_pc, 0);
      #1 chk("mrst_ready", in_ready, 1);
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         tick;
         if (out_valid !== 1'b0) bad++;
      end
      chk("mrst_discard", bad, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
